// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, state and instruction-field definitions for the ALU sequencer.
package alu_sequencer_pkg;

   // ALU opcodes; 4'hB..4'hE are unassigned and execute as illegal.
   localparam logic [3:0] OpAdd  = 4'h0;
   localparam logic [3:0] OpSub  = 4'h1;
   localparam logic [3:0] OpAnd  = 4'h2;
   localparam logic [3:0] OpOr   = 4'h3;
   localparam logic [3:0] OpNot  = 4'h4;
   localparam logic [3:0] OpAddi = 4'h5;
   localparam logic [3:0] OpSubi = 4'h6;
   localparam logic [3:0] OpMov  = 4'h7;
   localparam logic [3:0] OpMvi  = 4'h8;
   localparam logic [3:0] OpBc   = 4'h9;
   localparam logic [3:0] OpBs   = 4'hA;
   localparam logic [3:0] OpHlt  = 4'hF;

   // Sequencer states.
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StDecode = 3'd2;
   localparam logic [2:0] StExec   = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StHalt   = 3'd5;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] imm;
   } instr_t;

   // True for opcodes the ALU implements (HLT is handled before EXEC).
   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= OpBs;
   endfunction

endpackage

// File: rtl/alu_operand_sel.sv
// Combinational operand / bit-mask selection keyed on the instruction opcode.
module alu_operand_sel
   import alu_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [7:0] imm,
   input  logic [7:0] rdata_a,
   input  logic [7:0] rdata_b,
   output logic [7:0] op_a,
   output logic [7:0] op_b
);

   // Pick ALU operands; port A reads R[rd], port B reads R[rs].
   always_comb begin
      op_a = rdata_a;
      op_b = 8'h00;
      case (opcode)
         OpAdd, OpSub, OpAnd, OpOr: op_b = rdata_b;
         OpAddi, OpSubi:            op_b = imm;
         OpNot:                     op_b = 8'h00;
         OpMov:                     op_a = rdata_b;
         OpMvi:                     op_a = imm;
         OpBc, OpBs:                op_b = 8'h01 << imm[2:0];
         default: begin
            op_a = rdata_a;
            op_b = 8'h00;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit for the 8-bit ALU datapath.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned           PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [15:0]         imem_rdata,
   output logic [1:0]          rf_raddr_a,
   output logic [1:0]          rf_raddr_b,
   input  logic [7:0]          rf_rdata_a,
   input  logic [7:0]          rf_rdata_b,
   output logic                rf_we,
   output logic [1:0]          rf_waddr,
   output logic [7:0]          rf_wdata,
   output logic [3:0]          alu_opcode,
   output logic [7:0]          alu_op_a,
   output logic [7:0]          alu_op_b,
   input  logic [7:0]          alu_result,
   output logic [PC_WIDTH-1:0] pc,
   output logic                busy,
   output logic                halted,
   output logic                illegal
);

   logic [2:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   instr_t              ir_q, ir_d;
   logic [7:0]          op_a_q, op_a_d;
   logic [7:0]          op_b_q, op_b_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [7:0]          result_q, result_d;
   logic                illegal_q, illegal_d;
   logic [7:0]          sel_a, sel_b;

   alu_operand_sel u_operand_sel (
      .opcode  (ir_q.opcode),
      .imm     (ir_q.imm),
      .rdata_a (rf_rdata_a),
      .rdata_b (rf_rdata_b),
      .op_a    (sel_a),
      .op_b    (sel_b)
   );

   // Next-state logic for the sequencer FSM and its datapath registers.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      opcode_d  = opcode_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d   = StFetch;
               pc_d      = RESET_PC;
               illegal_d = 1'b0;
            end
         end
         StFetch: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            // HLT stops here without touching the ALU registers or the pc.
            if (ir_q.opcode == OpHlt) begin
               state_d = StHalt;
            end else begin
               op_a_d   = sel_a;
               op_b_d   = sel_b;
               opcode_d = ir_q.opcode;
               state_d  = StExec;
            end
         end
         StExec: begin
            if (!is_alu_op(opcode_q)) begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end else begin
               result_d = alu_result;
               state_d  = StWb;
            end
         end
         StWb: begin
            pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            state_d = StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         op_a_q    <= 8'h00;
         op_b_q    <= 8'h00;
         opcode_q  <= 4'h0;
         result_q  <= 8'h00;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         opcode_q  <= opcode_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      imem_req   = (state_q == StFetch);
      imem_addr  = pc_q;
      rf_raddr_a = ir_q.rd;
      rf_raddr_b = ir_q.rs;
      rf_we      = (state_q == StWb);
      rf_waddr   = ir_q.rd;
      rf_wdata   = result_q;
      alu_opcode = opcode_q;
      alu_op_a   = op_a_q;
      alu_op_b   = op_b_q;
      pc         = pc_q;
      busy       = (state_q == StFetch) || (state_q == StDecode) ||
                   (state_q == StExec)  || (state_q == StWb);
      halted     = (state_q == StHalt);
      illegal    = illegal_q;
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with imem, register file and ALU models.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [1:0]  rf_raddr_a, rf_raddr_b;
   logic [7:0]  rf_rdata_a, rf_rdata_b;
   logic        rf_we;
   logic [1:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_op_a, alu_op_b;
   logic [7:0]  alu_result;
   logic [7:0]  pc;
   logic        busy, halted, illegal;

   logic [15:0]     imem [256];
   logic [3:0][7:0] rf;
   logic [3:0][7:0] rf_init;
   logic            rf_load = 1'b0;
   int              wr_cnt = 0;
   logic [1:0]      last_waddr;
   logic [7:0]      last_wdata;
   logic [3:0]      ack_delay = 4'd0;
   logic            ack_force = 1'b0;
   logic [3:0]      wait_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_sequencer #(
      .PC_WIDTH (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_rdata_a (rf_rdata_a),
      .rf_rdata_b (rf_rdata_b),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .alu_opcode (alu_opcode),
      .alu_op_a   (alu_op_a),
      .alu_op_b   (alu_op_b),
      .alu_result (alu_result),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
   );

   // Instruction memory: ack after ack_delay cycles of request; garbage data off-ack.
   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 4'd0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
      else wait_cnt <= 4'd0;
   end
   assign imem_ack   = (imem_req && (wait_cnt >= ack_delay)) || ack_force;
   assign imem_rdata = imem_ack ? imem[imem_addr] : 16'hDEAD;

   // Register file model with bulk load and write logging.
   always @(posedge clk) begin
      if (rf_load) begin
         rf <= rf_init;
      end else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
         wr_cnt       <= wr_cnt + 1;
         last_waddr   <= rf_waddr;
         last_wdata   <= rf_wdata;
      end
   end
   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];

   function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
      case (op)
         4'h0, 4'h5: return a + b;
         4'h1, 4'h6: return a - b;
         4'h2:       return a & b;
         4'h3, 4'hA: return a | b;
         4'h4:       return ~a;
         4'h7, 4'h8: return a;
         4'h9:       return a & ~b;
         default:    return 8'h00;
      endcase
   endfunction
   assign alu_result = alu_model(alu_opcode, alu_op_a, alu_op_b);

   function automatic logic [3:0][7:0] rf4(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2, input logic [7:0] r3);
      return {r3, r2, r1, r0};
   endfunction

   typedef struct {
      logic [3:0][7:0] regs;
      logic [15:0]     instr;
      logic [1:0]      waddr;
      logic [7:0]      wdata;
      string           name;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_rf(input logic [3:0][7:0] v);
      @(negedge clk);
      rf_init = v;
      rf_load = 1'b1;
      @(negedge clk);
      rf_load = 1'b0;
   endtask

   // Leaves the bench at the negedge of the first FETCH cycle.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Cycle 1 is the first FETCH cycle; records the cycle of the first rf_we.
   task automatic wait_halt(input int max_cyc, output int we_cyc);
      int cyc = 1;
      we_cyc = -1;
      while (!halted && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (rf_we && we_cyc < 0) we_cyc = cyc;
      end
      check("halt_timeout", {31'd0, halted}, 32'd1);
   endtask

   initial begin
      int we_cyc;
      int w0;
      int k;

      for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
      rf_init = '0;
      rf      = '0;

      vecs[0]  = '{rf4(8'h05, 8'h03, 8'h00, 8'h00), 16'h0100, 2'd0, 8'h08, "add"};
      vecs[1]  = '{rf4(8'h00, 8'h10, 8'h11, 8'h00), 16'h1600, 2'd1, 8'hFF, "sub"};
      vecs[2]  = '{rf4(8'h00, 8'h00, 8'hF0, 8'h3C), 16'h2B00, 2'd2, 8'h30, "and"};
      vecs[3]  = '{rf4(8'hA0, 8'h00, 8'h00, 8'h0F), 16'h3C00, 2'd3, 8'hAF, "or"};
      vecs[4]  = '{rf4(8'h5A, 8'h00, 8'h00, 8'h00), 16'h4000, 2'd0, 8'hA5, "not"};
      vecs[5]  = '{rf4(8'h00, 8'h03, 8'h00, 8'h00), 16'h54FE, 2'd1, 8'h01, "addi"};
      vecs[6]  = '{rf4(8'h00, 8'h00, 8'h00, 8'h00), 16'h6801, 2'd2, 8'hFF, "subi"};
      vecs[7]  = '{rf4(8'h00, 8'h77, 8'h00, 8'h12), 16'h7D00, 2'd3, 8'h77, "mov"};
      vecs[8]  = '{rf4(8'h99, 8'h00, 8'h00, 8'h00), 16'h80C3, 2'd0, 8'hC3, "mvi"};
      vecs[9]  = '{rf4(8'h00, 8'h00, 8'h00, 8'h01), 16'hAC07, 2'd3, 8'h81, "bs"};
      vecs[10] = '{rf4(8'h00, 8'h00, 8'h00, 8'h81), 16'h9C00, 2'd3, 8'h80, "bc"};
      vecs[11] = '{rf4(8'h00, 8'h00, 8'h00, 8'h00), 16'hA40F, 2'd1, 8'h80, "bs_immmask"};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_flags", {29'd0, busy, halted, illegal}, 32'd0);
      check("rst_alu", {12'd0, alu_opcode, alu_op_a, alu_op_b}, 32'd0);
      check("rst_pc", {24'd0, pc}, 32'd0);
      rst = 1'b0;

      // Reset in the middle of a stalled fetch; a late ack must be ignored.
      w0 = wr_cnt;
      ack_delay = 4'd15;
      pulse_start();
      @(negedge clk);
      check("fetch_req_before_rst", {31'd0, imem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_drops_req", {31'd0, imem_req}, 32'd0);
      check("rst_mid_pc", {24'd0, pc}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      @(negedge clk);
      check("late_ack_idle", {30'd0, busy, imem_req}, 32'd0);
      check("late_ack_halted", {31'd0, halted}, 32'd0);
      check("late_ack_pc", {24'd0, pc}, 32'd0);
      check("late_ack_no_write", wr_cnt - w0, 32'd0);
      ack_delay = 4'd0;

      // Single instruction followed by HLT, zero-wait fetch.
      for (int i = 0; i < 12; i++) begin
         imem[0] = vecs[i].instr;
         imem[1] = 16'hF000;
         load_rf(vecs[i].regs);
         w0 = wr_cnt;
         pulse_start();
         wait_halt(50, we_cyc);
         check({vecs[i].name, "_we_cycle"}, we_cyc, 32'd4);
         check({vecs[i].name, "_nwrites"}, wr_cnt - w0, 32'd1);
         check({vecs[i].name, "_waddr"}, {30'd0, last_waddr}, {30'd0, vecs[i].waddr});
         check({vecs[i].name, "_wdata"}, {24'd0, last_wdata}, {24'd0, vecs[i].wdata});
         check({vecs[i].name, "_pc"}, {24'd0, pc}, 32'd1);
         check({vecs[i].name, "_illegal"}, {31'd0, illegal}, 32'd0);
      end

      // BS then BC on the same register.
      imem[0] = 16'hAC07;
      imem[1] = 16'h9C00;
      imem[2] = 16'hF000;
      load_rf(rf4(8'h00, 8'h00, 8'h00, 8'h01));
      w0 = wr_cnt;
      pulse_start();
      wait_halt(50, we_cyc);
      check("bsbc_nwrites", wr_cnt - w0, 32'd2);
      check("bsbc_r3", {24'd0, rf[3]}, 32'h80);
      check("bsbc_pc", {24'd0, pc}, 32'd2);

      // Delayed ack: request and address held until the ack cycle only.
      imem[0] = 16'h8442;
      imem[1] = 16'hF000;
      load_rf(rf4(8'h00, 8'h00, 8'h00, 8'h00));
      ack_delay = 4'd3;
      pulse_start();
      for (k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check("dly_req_held", {31'd0, imem_req}, 32'd1);
         check("dly_addr_stable", {24'd0, imem_addr}, 32'd0);
         check("dly_ack_timing", {31'd0, imem_ack}, (k == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check("dly_req_drops", {31'd0, imem_req}, 32'd0);
      wait_halt(60, we_cyc);
      check("dly_r1", {24'd0, rf[1]}, 32'h42);
      check("dly_illegal", {31'd0, illegal}, 32'd0);
      ack_delay = 4'd0;

      // Unassigned opcode halts with illegal set and no write; start recovers.
      imem[0] = 16'hB000;
      imem[1] = 16'hF000;
      load_rf(rf4(8'h33, 8'h33, 8'h33, 8'h33));
      w0 = wr_cnt;
      pulse_start();
      wait_halt(50, we_cyc);
      check("ill_flag", {31'd0, illegal}, 32'd1);
      check("ill_nwrites", wr_cnt - w0, 32'd0);
      check("ill_r0", {24'd0, rf[0]}, 32'h33);
      imem[0] = 16'h8811;
      pulse_start();
      check("ill_cleared", {31'd0, illegal}, 32'd0);
      check("ill_refetch", {23'd0, imem_req, imem_addr}, 32'h100);
      wait_halt(50, we_cyc);
      check("ill_resume_r2", {24'd0, rf[2]}, 32'h11);
      check("ill_resume_flag", {31'd0, illegal}, 32'd0);

      // pc wraps from 8'hFF to 8'h00 after WB.
      for (int i = 0; i < 255; i++) imem[i] = 16'h7000;
      imem[255] = 16'h7600;
      load_rf(rf4(8'h00, 8'h00, 8'h9C, 8'h00));
      pulse_start();
      k = 0;
      while (pc != 8'h01 && k < 100) begin
         @(negedge clk);
         k++;
      end
      imem[0] = 16'hF000;
      k = 0;
      while (pc != 8'hFF && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("wrap_reach_ff", {24'd0, pc}, 32'hFF);
      k = 0;
      while (!rf_we && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("wrap_wb_seen", {31'd0, rf_we}, 32'd1);
      check("wrap_wb_target", {22'd0, rf_waddr, rf_wdata}, {22'd0, 2'd1, 8'h9C});
      @(negedge clk);
      check("wrap_pc_zero", {24'd0, pc}, 32'd0);
      wait_halt(50, we_cyc);
      check("wrap_final_pc", {24'd0, pc}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit ALU datapath.
- Fetches 16-bit instructions over a req/ack instruction-memory handshake, then decodes them.
- Reads a 4x8 external register file, drives the ALU opcode and operands, captures the result and writes it back.
- Sits between instruction memory, register file and ALU as the CPU control unit.

Parameters:
- PC_WIDTH, 8, width of program counter / imem address
- RESET_PC, 0, PC value loaded on reset and on start

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins execution at RESET_PC when in IDLE or HALT
- imem_req  output  1  fetch request, held until ack
- imem_addr  output  PC_WIDTH  fetch address (= pc)
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  16  instruction word
- rf_raddr_a  output  2  register file read address A (combinational read)
- rf_raddr_b  output  2  register file read address B
- rf_rdata_a  input  8  read data A
- rf_rdata_b  input  8  read data B
- rf_we  output  1  register write enable, one cycle
- rf_waddr  output  2  write address
- rf_wdata  output  8  write data
- alu_opcode  output  4  to ALU opcode
- alu_op_a  output  8  to ALU op_a
- alu_op_b  output  8  to ALU op_b
- alu_result  input  8  from ALU result (combinational)
- pc  output  PC_WIDTH  current program counter
- busy  output  1  high in FETCH/DECODE/EXEC/WB
- halted  output  1  high in HALT
- illegal  output  1  sticky: unknown opcode executed

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, all outputs 0 (imem_req, rf_we, busy, halted, illegal low; alu_* = 0). Reset mid-fetch drops imem_req immediately; any pending ack is ignored.
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- IDLE: on start -> FETCH, pc=RESET_PC.
- FETCH: imem_req=1, imem_addr=pc stable. On imem_ack: latch imem_rdata into ir -> DECODE. imem_req drops the cycle after ack.
- DECODE: rf_raddr_a=rd, rf_raddr_b=rs. Operands are registered into op_a/op_b regs and alu_opcode is registered from ir -> EXEC.
- Operand rules:
  - ADD/SUB/AND/OR: a=R[rd], b=R[rs].
  - ADDI/SUBI: a=R[rd], b=imm.
  - NOT: a=R[rd], b=0.
  - MOV: a=R[rs], b=0.
  - MVI: a=imm, b=0.
  - BC/BS: a=R[rd], b=8'h01<<imm[2:0].
- EXEC: alu_result is captured into the result reg -> WB. Unknown opcode: illegal=1 -> HALT, no write.
- WB: rf_we=1 for exactly one cycle, rf_waddr=rd, rf_wdata=result. pc=pc+1 (modulo 2^PC_WIDTH, wraps to 0) -> FETCH.
- HLT opcode: decoded in DECODE -> HALT directly; no ALU use, no write, pc not incremented.
- HALT: halted=1, busy=0. Start -> FETCH at RESET_PC, clears halted and illegal.
- start is ignored while busy.
- Latency: instruction = fetch wait (≥1 cycle incl. ack cycle) + DECODE + EXEC + WB = 4 cycles minimum with zero-wait ack.
- Arithmetic is 8-bit, wrap-around; carry/borrow not tracked.
- alu_* outputs are held stable from DECODE exit through EXEC.

Decomposition:
- Shared defines.v holds the opcode macros (existing ADD..BS plus new HLT=4'hF) and state encodings (IDLE, FETCH, DECODE, EXEC, WB, HALT, 3-bit).
- One natural sub-module: alu_operand_sel, a combinational operand/mask mux keyed on opcode.
- The ALU itself is instantiated beside the sequencer at CPU top, not inside it.

Test Plan:
- Reset during FETCH with imem_req high, then an ack 2 cycles later -> imem_req low at reset assertion; state IDLE; pc=0; no rf_we ever.
- R0=8'h05, R1=8'h03, program {ADD r0,r1; HLT}, zero-wait ack -> rf_we one cycle 4 cycles after start with waddr=0, wdata=8'h08; then halted=1, pc=1.
- SUBI r2 with imm=1 and R2=8'h00 -> wdata=8'hFF (wrap).
- BS r3 bit 7 with R3=8'h01 -> wdata=8'h81. Then BC r3 bit 0 (R3=8'h81) -> wdata=8'h80.
- imem_ack delayed 3 cycles -> imem_addr stable and imem_req high throughout; instruction latches only on the ack cycle.
- Opcode with no define (if any free code) -> illegal=1, halted=1, no write. Then start pulse -> illegal cleared, fetch resumes at pc=0.
- PC_WIDTH=8 with pc=8'hFF executing MOV -> pc wraps to 8'h00 after WB.
